// File: rtl/rr_sched_pkg.sv
// Shared types and sizing for the round-robin grant scheduler.
// Eight requesters, a 3-bit owner index and a 16-bit select bus for the downstream decoder.
package rr_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int SEL_W   = 16;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Stateless rotating-priority search: starting at ptr and wrapping modulo NUM_REQ,
// the first asserted request wins.
module rr_pick
  import rr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   winner
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   offset;

  // rot[k] is the request sitting k places after the pointer
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W-1:0] src;
      assign src     = ptr + IDX_W'(gi);
      assign rot[gi] = req[src];
    end
  endgenerate

  // Scan downward so the lowest rotated position is the last (winning) assignment
  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = IDX_W'(k);
      end
    end
  end

  assign any    = |req;
  assign winner = ptr + offset;

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: IDLE -> BUSY (owner holds) -> GAP (one dead cycle) -> IDLE.
// A grant is revoked by done, by the owner dropping its request, or by the MAX_HOLD limit.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [SEL_W-1:0]   grant_onehot,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic               grant_valid_reg, grant_valid_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [SEL_W-1:0]   grant_onehot_reg, grant_onehot_next;
  logic               timeout_reg, timeout_next;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_winner;
  logic               hold_hit;
  logic               owner_req;
  logic               release_now;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .any    (pick_any),
    .winner (pick_winner)
  );

  assign hold_hit    = (hold_cnt_reg == HOLD_LAST);
  assign owner_req   = req[grant_idx_reg];
  assign release_now = done || !owner_req || hold_hit;

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    hold_cnt_next    = hold_cnt_reg;
    grant_valid_next = grant_valid_reg;
    grant_idx_next   = grant_idx_reg;
    timeout_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next       = BUSY;
          grant_valid_next = 1'b1;
          grant_idx_next   = pick_winner;
          ptr_next         = pick_winner + IDX_W'(1);
          hold_cnt_next    = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_next       = GAP;
          grant_valid_next = 1'b0;
          // A timeout is reported only when the hold limit alone ended the grant
          timeout_next     = hold_hit && !done && owner_req;
        end else if (!hold_hit) begin
          hold_cnt_next    = hold_cnt_reg + HOLD_W'(1);
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next       = IDLE;
        grant_valid_next = 1'b0;
      end
    endcase
  end

  // Decoder select is derived from the next-state grant so it registers alongside it
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign grant_onehot_next[gi] = grant_valid_next && (grant_idx_next == IDX_W'(gi));
    end
  endgenerate
  assign grant_onehot_next[SEL_W-1:NUM_REQ] = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      hold_cnt_reg     <= '0;
      grant_valid_reg  <= 1'b0;
      grant_idx_reg    <= '0;
      grant_onehot_reg <= '0;
      timeout_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ptr_reg          <= ptr_next;
      hold_cnt_reg     <= hold_cnt_next;
      grant_valid_reg  <= grant_valid_next;
      grant_idx_reg    <= grant_idx_next;
      grant_onehot_reg <= grant_onehot_next;
      timeout_reg      <= timeout_next;
    end
  end

  assign grant_valid  = grant_valid_reg;
  assign grant_idx    = grant_idx_reg;
  assign grant_onehot = grant_onehot_reg;
  assign timeout      = timeout_reg;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: one instance with MAX_HOLD=4, one with MAX_HOLD=1,
// hand-computed expectations checked with immediate assertions.
module tb_rr_grant_scheduler;

  logic        clk;
  logic        reset;
  logic [7:0]  req;
  logic        done;

  logic        grant_valid;
  logic [2:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        timeout;

  logic        grant_valid1;
  logic [2:0]  grant_idx1;
  logic [15:0] grant_onehot1;
  logic        timeout1;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  rr_grant_scheduler #(.MAX_HOLD(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  rr_grant_scheduler #(.MAX_HOLD(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid1),
    .grant_idx    (grant_idx1),
    .grant_onehot (grant_onehot1),
    .timeout      (timeout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                         input logic [15:0] oh, input logic to);
    chk({tag, ".valid"},   32'(grant_valid),  32'(v));
    chk({tag, ".idx"},     32'(grant_idx),    32'(idx));
    chk({tag, ".onehot"},  32'(grant_onehot), 32'(oh));
    chk({tag, ".timeout"}, 32'(timeout),      32'(to));
    $display("step %-10s valid=%0d idx=%0d onehot=%04h timeout=%0d", tag,
             grant_valid, grant_idx, grant_onehot, timeout);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select-bus invariants on both instances every cycle
  always @(negedge clk) begin
    if (inv_en) begin
      chk("inv.hi",   32'(grant_onehot[15:8]), 32'h0);
      chk("inv.pop",  32'($countones(grant_onehot)), 32'(grant_valid));
      chk("inv1.hi",  32'(grant_onehot1[15:8]), 32'h0);
      chk("inv1.pop", 32'($countones(grant_onehot1)), 32'(grant_valid1));
    end
  end

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 3'd0, 16'h0000, 1'b0);
    chk("reset.ptr", 32'(dut.ptr_reg), 32'd0);
    inv_en = 1'b1;

    // Single requester, released by done in its 3rd BUSY cycle
    reset = 1'b0;
    req   = 8'h01;
    tick();
    chk_out("a.busy1", 1'b1, 3'd0, 16'h0001, 1'b0);
    chk("a.ptr", 32'(dut.ptr_reg), 32'd1);
    tick();
    chk_out("a.busy2", 1'b1, 3'd0, 16'h0001, 1'b0);
    tick();
    chk_out("a.busy3", 1'b1, 3'd0, 16'h0001, 1'b0);
    done = 1'b1;
    tick();
    chk_out("a.gap", 1'b0, 3'd0, 16'h0000, 1'b0);
    done = 1'b0;
    tick();
    chk_out("a.idle", 1'b0, 3'd0, 16'h0000, 1'b0);
    tick();
    chk_out("a.regrant", 1'b1, 3'd0, 16'h0001, 1'b0);
    req = 8'h00;
    tick();
    chk_out("a.drop", 1'b0, 3'd0, 16'h0000, 1'b0);
    tick();

    // All requesting, done held: rotation 0..7 then wrap to 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 8'hFF;
    done  = 1'b1;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk_out($sformatf("b.g%0d", g), 1'b1, 3'(g % 8), 16'h0001 << (g % 8), 1'b0);
      if (g == 7) chk("b.ptrwrap", 32'(dut.ptr_reg), 32'd0);
      tick();
      chk_out($sformatf("b.gap%0d", g), 1'b0, 3'(g % 8), 16'h0000, 1'b0);
      tick();
      chk_out($sformatf("b.idle%0d", g), 1'b0, 3'(g % 8), 16'h0000, 1'b0);
    end
    done = 1'b0;

    // Hold limit: owner 5 keeps requesting, revoked after 4 cycles with a timeout pulse
    req = 8'h20;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out($sformatf("c.busy%0d", c), 1'b1, 3'd5, 16'h0020, 1'b0);
    end
    tick();
    chk_out("c.timeout", 1'b0, 3'd5, 16'h0000, 1'b1);
    tick();
    chk_out("c.idle", 1'b0, 3'd5, 16'h0000, 1'b0);
    tick();
    chk_out("c.repeat", 1'b1, 3'd5, 16'h0020, 1'b0);
    req = 8'h00;
    tick();
    chk_out("c.drop", 1'b0, 3'd5, 16'h0000, 1'b0);
    tick();

    // Owner 3 drops its request; GAP ignores pending reqs; next grant goes to 4
    req = 8'h08;
    tick();
    chk_out("d.grant3", 1'b1, 3'd3, 16'h0008, 1'b0);
    req = 8'h11;
    tick();
    chk_out("d.gap", 1'b0, 3'd3, 16'h0000, 1'b0);
    tick();
    chk_out("d.idle", 1'b0, 3'd3, 16'h0000, 1'b0);
    tick();
    chk_out("d.grant4", 1'b1, 3'd4, 16'h0010, 1'b0);
    req = 8'h00;
    tick();
    tick();

    // Reset mid-BUSY, then wrap from winner 7, then reset during GAP
    req = 8'h01;
    tick();
    chk_out("e.busy1", 1'b1, 3'd0, 16'h0001, 1'b0);
    tick();
    chk_out("e.busy2", 1'b1, 3'd0, 16'h0001, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("e.reset", 1'b0, 3'd0, 16'h0000, 1'b0);
    chk("e.ptr", 32'(dut.ptr_reg), 32'd0);
    reset = 1'b0;
    req   = 8'h80;
    tick();
    chk_out("e.grant7", 1'b1, 3'd7, 16'h0080, 1'b0);
    chk("e.ptrwrap", 32'(dut.ptr_reg), 32'd0);
    req = 8'h00;
    tick();
    chk_out("e.gap", 1'b0, 3'd7, 16'h0000, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("e.gapreset", 1'b0, 3'd0, 16'h0000, 1'b0);
    reset = 1'b0;

    // MAX_HOLD=1 instance: each grant lasts exactly one BUSY cycle
    req = 8'h04;
    tick();
    chk("f.valid1", 32'(grant_valid1), 32'd1);
    chk("f.idx1",   32'(grant_idx1),   32'd2);
    chk("f.oh1",    32'(grant_onehot1), 32'h0004);
    tick();
    chk("f.valid2", 32'(grant_valid1), 32'd0);
    chk("f.to2",    32'(timeout1),     32'd1);
    tick();
    chk("f.to3",    32'(timeout1),     32'd0);
    tick();
    chk("f.valid4", 32'(grant_valid1), 32'd1);
    chk("f.idx4",   32'(grant_idx1),   32'd2);
    $display("step f.hold1   valid=%0d idx=%0d onehot=%04h timeout=%0d",
             grant_valid1, grant_idx1, grant_onehot1, timeout1);
    req = 8'h00;
    tick();
    tick();

    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum consecutive BUSY cycles per grant; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  request vector; bit i = requester i.
REQ-005 done  input  1  owner release strobe; sampled only in BUSY.
REQ-006 grant_valid  output  1  a grant is active.
REQ-007 grant_idx  output  3  index of current owner.
REQ-008 grant_onehot  output  16  one-hot select for the 3-to-8 select decoder; bits [15:8] always 0.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-010 FSM states: IDLE, BUSY, GAP; all outputs SHALL be registered.
REQ-011 Priority pointer ptr[2:0]: search order ptr, ptr+1, ... ptr+7, mod 8; first set req bit wins.
REQ-012 IDLE, req != 0 at edge N: after edge N, state=BUSY, grant_valid=1, grant_idx=winner, ptr=winner+1 mod 8, hold_cnt=0.
REQ-013 IDLE, req == 0: remain IDLE; ptr unchanged.
REQ-014 BUSY: hold_cnt increments each cycle, saturating at MAX_HOLD-1.
REQ-015 BUSY release on any of: done=1; req[grant_idx]=0; hold_cnt==MAX_HOLD-1.
REQ-016 On release at edge M: state=GAP, grant_valid=0, grant_onehot=0, grant_idx holds last value.
REQ-017 timeout=1 for exactly the cycle after edge M only if release caused solely by hold limit (done=0 and req[grant_idx]=1); otherwise 0.
REQ-018 GAP: unconditionally -> IDLE after one cycle; req ignored; earliest next grant after edge M+2.
REQ-019 grant_onehot[i]=1 iff grant_valid=1 and grant_idx==i, i in 0..7; all zero otherwise.
REQ-020 Wrap-around: winner 7 SHALL set ptr=0.
REQ-021 MAX_HOLD=1: every grant lasts exactly one BUSY cycle.
REQ-022 done while not BUSY SHALL be ignored.
REQ-023 Fairness: a continuously asserted request SHALL be granted within 8 grants.

Reset
REQ-024 reset=1 at an edge: state=IDLE, ptr=0, hold_cnt=0, grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0.
REQ-025 reset SHALL take priority over every transition, including mid-BUSY and in GAP; no timeout pulse results.
REQ-026 First grant possible after the first edge with reset=0.

Structure
REQ-027 Package rr_sched_pkg SHALL hold the state enum (IDLE, BUSY, GAP), NUM_REQ=8, IDX_W=3, SEL_W=16.
REQ-028 Sub-module rr_pick SHALL contain the rotating priority search (req, ptr -> any, winner idx); it contains no state.
REQ-029 Top level SHALL hold FSM, ptr, hold_cnt and output registers.

Verification
REQ-030 Reset, then req=8'h01 held, done pulse on the 3rd BUSY cycle -> grant_idx=0, grant_onehot=16'h0001, valid for 3 cycles, then GAP, then re-grant to 0.
REQ-031 req=8'hFF held, done every BUSY cycle -> grant order 0,1,2,...,7,0; ptr wraps 7->0.
REQ-032 MAX_HOLD=4, req=8'h20 held, done=0 -> grant_idx=5, onehot=16'h0020 for 4 cycles, timeout pulse, repeats.
REQ-033 Owner 3 drops req[3] in BUSY while req=8'h11 -> release, timeout=0, next grant to 4 after GAP.
REQ-034 reset asserted on 2nd BUSY cycle -> next cycle all outputs 0, ptr=0; after reset req=8'h80 -> grant_idx=7.
REQ-035 Each cycle, assert grant_onehot[15:8]==0 and popcount(grant_onehot)==grant_valid.
